// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship monster controller.
//
// Contents:
//   game_state_e : global game FSM encoding (one-hot INIT/PLAY/OVER)
//   ch_state_e   : per-channel monster FSM encoding
//   LFSR_W       : width of the spawn-delay LFSR
//   LFSR_TAPS    : feedback taps 16,14,13,11 expressed as a bit mask
//   lfsr_step()  : one Fibonacci shift of the LFSR
package nexys_starship_pkg;

    typedef enum logic [2:0] {
        INIT = 3'b001,
        PLAY = 3'b010,
        OVER = 3'b100
    } game_state_e;

    typedef enum logic [1:0] {
        CH_EMPTY  = 2'b00,
        CH_FULL   = 2'b01,
        CH_BROKEN = 2'b10
    } ch_state_e;

    localparam int LFSR_W = 16;

    // Tap positions 16,14,13,11 (1-based) map to bits 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/nexys_starship_monster_ctrl_if.sv
// Handshake/bus bundle between the game-tick generator / button
// debouncers (master side) and the monster controller (slave side).
//
// Signals:
//   tick      : one-cycle game-time pulse
//   play      : start / restart pulse
//   shoot     : per-channel fire pulses
//   repair    : per-channel repair pulses
//   monster   : per-channel FULL flags
//   broken    : per-channel BROKEN flags
//   playing   : game is in PLAY
//   game_over : game is in OVER
//   score     : saturating count of monsters destroyed this game
interface nexys_starship_monster_ctrl_if #(
    parameter int NUM_CH  = 4,
    parameter int SCORE_W = 16
) ();

    logic               tick;
    logic               play;
    logic [NUM_CH-1:0]  shoot;
    logic [NUM_CH-1:0]  repair;
    logic [NUM_CH-1:0]  monster;
    logic [NUM_CH-1:0]  broken;
    logic               playing;
    logic               game_over;
    logic [SCORE_W-1:0] score;

    modport master (
        output tick, play, shoot, repair,
        input  monster, broken, playing, game_over, score
    );

    modport slave (
        input  tick, play, shoot, repair,
        output monster, broken, playing, game_over, score
    );

endinterface

// File: rtl/nexys_starship_monster_ch.sv
// Single monster channel: EMPTY -> FULL -> BROKEN state machine with its
// own countdown timer. The top module decides whether the channel runs,
// is cleared, or is (re)armed with a fresh spawn delay.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   run         : game is in PLAY; channel FSM is live
//   start       : game is starting; load spawn_val, stay EMPTY
//   clear       : force EMPTY with timer 0
//   tick        : game-time pulse
//   shoot       : player fires at this channel
//   repair      : player repairs this channel
//   spawn_val   : spawn delay to load when the channel empties
//   full        : channel currently FULL
//   broken      : channel currently BROKEN
//   broken_next : channel will be BROKEN after this edge
//   kill        : a shot is accepted on this edge
module nexys_starship_monster_ch
    import nexys_starship_pkg::*;
#(
    parameter int TMR_W        = 8,
    parameter int ATTACK_TICKS = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             start,
    input  logic             clear,
    input  logic             tick,
    input  logic             shoot,
    input  logic             repair,
    input  logic [TMR_W-1:0] spawn_val,
    output logic             full,
    output logic             broken,
    output logic             broken_next,
    output logic             kill
);

    localparam logic [TMR_W-1:0] ATTACK_VAL = TMR_W'(ATTACK_TICKS);
    localparam logic [TMR_W-1:0] ONE        = TMR_W'(1);

    ch_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CH_EMPTY;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // A timer value of 0 or 1 both count as "expiring": 0 only happens
    // when a spawn delay truncated to zero, and must still spawn.
    // A shot on FULL beats an expiring tick on the same edge.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        kill    = 1'b0;
        if (clear) begin
            state_d = CH_EMPTY;
            timer_d = '0;
        end else if (start) begin
            state_d = CH_EMPTY;
            timer_d = spawn_val;
        end else if (run) begin
            unique case (state_q)
                CH_EMPTY: begin
                    if (tick) begin
                        if (timer_q <= ONE) begin
                            state_d = CH_FULL;
                            timer_d = ATTACK_VAL;
                        end else begin
                            timer_d = timer_q - ONE;
                        end
                    end
                end
                CH_FULL: begin
                    if (shoot) begin
                        state_d = CH_EMPTY;
                        timer_d = spawn_val;
                        kill    = 1'b1;
                    end else if (tick) begin
                        if (timer_q <= ONE) begin
                            state_d = CH_BROKEN;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q - ONE;
                        end
                    end
                end
                CH_BROKEN: begin
                    if (repair) begin
                        state_d = CH_EMPTY;
                        timer_d = spawn_val;
                    end
                end
                default: begin
                    state_d = CH_EMPTY;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign full        = (state_q == CH_FULL);
    assign broken      = (state_q == CH_BROKEN);
    assign broken_next = (state_d == CH_BROKEN);

endmodule

// File: rtl/nexys_starship_monster_ctrl.sv
// Nexys Starship monster controller: NUM_CH independent monster channels
// sharing one LFSR-driven spawn delay, plus the global INIT/PLAY/OVER
// game FSM, broken-channel counting and the saturating score.
//
// Ports:
//   Clk   : system clock
//   Reset : asynchronous, active-high reset
//   bus   : slave side of nexys_starship_monster_ctrl_if
//           (tick/play/shoot/repair in; monster/broken/playing/
//            game_over/score out)
module nexys_starship_monster_ctrl
    import nexys_starship_pkg::*;
#(
    parameter int              NUM_CH       = 4,
    parameter int              TMR_W        = 8,
    parameter int              ATTACK_TICKS = 50,
    parameter int              SPAWN_MIN    = 10,
    parameter logic [7:0]      SPAWN_MASK   = 8'h3F,
    parameter int              MAX_BROKEN   = 2,
    parameter int              SCORE_W      = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    nexys_starship_monster_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int SUM_W = SCORE_W + CNT_W;
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

    game_state_e        game_q, game_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic [TMR_W-1:0]   spawn_val;
    logic               ch_run, ch_start, ch_clear;
    logic [NUM_CH-1:0]  ch_full, ch_broken, ch_broken_next, ch_kill;
    logic [CNT_W-1:0]   broken_cnt, kill_cnt;
    logic [SUM_W-1:0]   score_sum;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            game_q  <= INIT;
            lfsr_q  <= LFSR_SEED;
            score_q <= '0;
        end else begin
            game_q  <= game_d;
            lfsr_q  <= lfsr_d;
            score_q <= score_d;
        end
    end

    // Every channel loading on the same edge samples the same LFSR value.
    always_comb begin
        spawn_val = TMR_W'(SPAWN_MIN + int'(lfsr_q[7:0] & SPAWN_MASK));
    end

    // Channels run only in PLAY; INIT holds them cleared except on the
    // starting edge, and leaving OVER clears them. OVER alone freezes them.
    always_comb begin
        ch_run   = (game_q == PLAY);
        ch_start = (game_q == INIT) && bus.play;
        ch_clear = ((game_q == INIT) && !bus.play) || ((game_q == OVER) && bus.play);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nexys_starship_monster_ch #(
            .TMR_W        (TMR_W),
            .ATTACK_TICKS (ATTACK_TICKS)
        ) u_ch (
            .clk         (Clk),
            .rst         (Reset),
            .run         (ch_run),
            .start       (ch_start),
            .clear       (ch_clear),
            .tick        (bus.tick),
            .shoot       (bus.shoot[i]),
            .repair      (bus.repair[i]),
            .spawn_val   (spawn_val),
            .full        (ch_full[i]),
            .broken      (ch_broken[i]),
            .broken_next (ch_broken_next[i]),
            .kill        (ch_kill[i])
        );
    end

    // Counts use the post-update channel states so that a break and a
    // repair on the same edge cancel out before the game-over decision.
    always_comb begin
        broken_cnt = '0;
        kill_cnt   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            broken_cnt = broken_cnt + CNT_W'(ch_broken_next[i]);
            kill_cnt   = kill_cnt + CNT_W'(ch_kill[i]);
        end
        score_sum = SUM_W'(score_q) + SUM_W'(kill_cnt);
    end

    always_comb begin
        lfsr_d  = lfsr_step(lfsr_q);
        game_d  = game_q;
        score_d = score_q;
        unique case (game_q)
            INIT: begin
                score_d = '0;
                if (bus.play) begin
                    game_d = PLAY;
                end
            end
            PLAY: begin
                score_d = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
                if (broken_cnt >= CNT_W'(MAX_BROKEN)) begin
                    game_d = OVER;
                end
            end
            OVER: begin
                if (bus.play) begin
                    game_d  = INIT;
                    score_d = '0;
                end
            end
            default: begin
                game_d  = INIT;
                score_d = '0;
            end
        endcase
    end

    assign bus.monster   = ch_full;
    assign bus.broken    = ch_broken;
    assign bus.playing   = (game_q == PLAY);
    assign bus.game_over = (game_q == OVER);
    assign bus.score     = score_q;

endmodule

// File: doc/nexys_starship_monster_ctrl.md
Name: nexys_starship_monster_ctrl

Overview:
- Parametrised monster controller for Nexys Starship; one instance replaces the per-side single-monster blocks.
- Manages NUM_CH independent monster channels (top, bottom, left, right, …), each with its own spawn and attack timer.
- Spawn delays are randomised by an internal LFSR. The block tracks broken channels, player score and the game-over condition.
- Sits between the game-tick generator / button debouncers and the VGA display and scoring logic.

Parameters:
- NUM_CH, 4, number of monster channels
- TMR_W, 8, width of every per-channel countdown timer
- ATTACK_TICKS, 50, ticks a monster survives before breaking its channel (1..2^TMR_W-1)
- SPAWN_MIN, 10, minimum ticks between a channel emptying and the next spawn
- SPAWN_MASK, 8'h3F, mask applied to LFSR bits to form the random extra spawn delay
- MAX_BROKEN, 2, number of simultaneously broken channels that ends the game (1..NUM_CH)
- SCORE_W, 16, score width
- LFSR_SEED, 16'hACE1, non-zero reset seed of the 16-bit LFSR

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- tick  in  1  one-Clk game-time pulse; all timers advance only on tick
- play  in  1  start pulse; leaves INIT, and returns OVER to INIT
- shoot  in  NUM_CH  one-Clk pulse per channel: player fires at that side
- repair  in  NUM_CH  one-Clk pulse per channel: player repairs that side
- monster  out  NUM_CH  1 = channel FULL
- broken  out  NUM_CH  1 = channel BROKEN
- playing  out  1  1 = global state PLAY
- game_over  out  1  1 = global state OVER
- score  out  SCORE_W  monsters destroyed this game, saturating

Behaviour:
- Reset (asynchronous, active-high):
  - global state INIT; every channel EMPTY with timer 0.
  - outputs: monster=0, broken=0, playing=0, game_over=0, score=0.
  - LFSR is set to LFSR_SEED.
- All outputs are registered and change only on posedge Clk, except when Reset asserts.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Steps every Clk in every state, so its value depends on play timing.
- Global FSM:
  - INIT: channels held EMPTY, score held at 0. play -> PLAY; on that same edge every channel loads its spawn timer.
  - PLAY: goes to OVER on the edge where the registered broken-channel count, after this cycle's updates, is >= MAX_BROKEN.
  - OVER: channels frozen (monster/broken hold their last values), timers stop, score holds. play -> INIT; that edge clears channels and score.
- Per-channel FSM (active only in PLAY), for channel i:
  - EMPTY: on tick, decrement the timer. On the tick where timer==1 (or an entry value of 0) -> FULL, load ATTACK_TICKS.
  - FULL: shoot[i] -> EMPTY; score+1 (saturates at all-ones); reload spawn timer.
  - FULL: on tick, decrement the timer; on the tick where timer==1 -> BROKEN.
  - BROKEN: repair[i] -> EMPTY, reload spawn timer. shoot[i] is ignored.
  - Spawn timer load value = SPAWN_MIN + (LFSR[7:0] & SPAWN_MASK), truncated to TMR_W. Every channel uses the same LFSR sample; channels loading on the same edge therefore get equal delays.
  - shoot[i] in EMPTY and repair[i] in EMPTY/FULL have no effect.
- Simultaneous events:
  - shoot[i] and an expiring tick on the same edge: shoot wins (EMPTY, score+1).
  - Several channels shot on one edge: score increases by their popcount, saturating.
  - A channel breaking and another being repaired on one edge: the net count decides game over.
- Latency: monster/broken reflect an event one Clk after the sampling edge.
- Reset mid-game: returns to INIT immediately; no partial score is kept.

Decomposition:
- Package nexys_starship_pkg holds:
  - global state encodings INIT=3'b001, PLAY=3'b010, OVER=3'b100;
  - channel encodings CH_EMPTY=2'b00, CH_FULL=2'b01, CH_BROKEN=2'b10;
  - LFSR tap constants.
- One sub-module is natural: nexys_starship_monster_ch, a single-channel FSM plus timer, instantiated NUM_CH times with a generate loop.
- Score adder, broken counter, LFSR and global FSM stay in the top module.

Test Plan:
- Reset and start: assert Reset mid-PLAY with score=5 -> all outputs 0 immediately. Pulse play -> playing=1 next Clk, monster=0.
- Spawn timing: SPAWN_MASK=0, SPAWN_MIN=3; pulse play, then 3 ticks -> monster=4'b1111 one Clk after the 3rd tick.
- Kill: shoot=4'b0101 while all FULL -> monster=4'b1010, score=2 next Clk. Same-edge expiring tick on ch0 + shoot[0] -> ch0 EMPTY, not broken.
- Break and repair: ATTACK_TICKS=5, no shots on ch1 -> broken[1]=1 after the 5th tick. repair[1] -> broken[1]=0, ch1 respawns after the spawn delay.
- Game over: MAX_BROKEN=2; let ch0 and ch2 expire on the same tick -> broken=4'b0101, game_over=1, playing=0. Further ticks and shots change nothing. play -> INIT, score=0.
- Saturation: SCORE_W=4; 17 kills -> score=4'hF.
